// File: rtl/ram_arbiter.sv
// Two-requester (cpu/dma) round-robin arbiter for a single-port RAM with a fixed WAIT_CYC access window.
// Latency: grant at the IDLE edge, ACCESS for WAIT_CYC cycles, one-cycle ack in DONE; requesters hold req until ack.
module ram_arbiter #(
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  rd_data,
  output logic        ram_en,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rd_q, rd_d;
  logic        grant_dma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 15'd0;
      wdata_q <= 8'd0;
      rd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end

  // On a tie the requester that did not own the last transaction wins.
  assign grant_dma = dma_req && (!cpu_req || !owner_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d = ACCESS;
          owner_d = grant_dma;
          we_d    = grant_dma ? dma_we    : cpu_we;
          addr_d  = grant_dma ? dma_addr  : cpu_addr;
          wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          cnt_d   = 4'(WAIT_CYC - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) rd_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from the state register so a reset drops them without a clock.
  always_comb begin
    ram_en    = (state_q == ACCESS);
    ram_we    = (state_q == ACCESS) && we_q;
    cpu_ack   = (state_q == DONE) && !owner_q;
    dma_ack   = (state_q == DONE) && owner_q;
    busy      = (state_q != IDLE);
    owner     = owner_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    rd_data   = rd_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: WAIT_CYC=2 instance for function/arbitration/reset, WAIT_CYC=15 instance for the long wait.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [14:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_ack, dma_ack, ram_en, ram_we, busy, owner;
  logic [7:0]  rd_data, ram_wdata, ram_rdata;
  logic [14:0] ram_addr;

  logic        cpu_req15;
  logic        cpu_ack15, dma_ack15, ram_en15, ram_we15, busy15, owner15;
  logic [7:0]  rd_data15, ram_wdata15, ram_rdata15;
  logic [14:0] ram_addr15;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // RAM model: 0x0100 holds 0x5A, every other address returns addr[7:0]^0xA5.
  function automatic logic [7:0] mem_rd(input logic [14:0] a);
    return (a == 15'h0100) ? 8'h5A : (a[7:0] ^ 8'hA5);
  endfunction

  assign ram_rdata   = mem_rd(ram_addr);
  assign ram_rdata15 = mem_rd(ram_addr15);

  ram_arbiter #(.WAIT_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rd_data(rd_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  ram_arbiter #(.WAIT_CYC(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req15), .cpu_we(1'b0), .cpu_addr(15'h0100), .cpu_wdata(8'h00), .cpu_ack(cpu_ack15),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(15'h0000), .dma_wdata(8'h00), .dma_ack(dma_ack15),
    .rd_data(rd_data15), .ram_en(ram_en15), .ram_we(ram_we15), .ram_addr(ram_addr15), .ram_wdata(ram_wdata15),
    .ram_rdata(ram_rdata15), .busy(busy15), .owner(owner15)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one transaction from IDLE with WAIT_CYC=2, checking every cycle; called at a negedge.
  task automatic run_txn(input string nm, input bit d, input bit we, input logic [14:0] a,
                         input logic [7:0] wd, input logic [7:0] exp_rd);
    if (d) begin
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk({nm, "_acc_en"}, 32'(ram_en), 32'd1);
      chk({nm, "_acc_we"}, 32'(ram_we), 32'(we));
      chk({nm, "_acc_addr"}, 32'(ram_addr), 32'(a));
      if (we) chk({nm, "_acc_wdata"}, 32'(ram_wdata), 32'(wd));
      chk({nm, "_acc_owner"}, 32'(owner), 32'(d));
      chk({nm, "_acc_busy"}, 32'(busy), 32'd1);
      chk({nm, "_acc_noack"}, 32'({cpu_ack, dma_ack}), 32'd0);
    end
    @(negedge clk);
    chk({nm, "_done_en"}, 32'({ram_en, ram_we}), 32'd0);
    chk({nm, "_done_ack"}, 32'({cpu_ack, dma_ack}), d ? 32'd1 : 32'd2);
    chk({nm, "_done_rd"}, 32'(rd_data), 32'(exp_rd));
    chk({nm, "_done_busy"}, 32'(busy), 32'd1);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_ack"}, 32'({cpu_ack, dma_ack}), 32'd0);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acks, en_cnt, ack_cyc;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu_req15 = 1'b0;

    @(negedge clk);
    chk("rst_en_we", 32'({ram_en, ram_we}), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_ack", 32'({cpu_ack, dma_ack}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd1);
    rst_n = 1'b1;

    run_txn("cpu_rd", 1'b0, 1'b0, 15'h0100, 8'h00, 8'h5A);
    run_txn("cpu_wr", 1'b0, 1'b1, 15'h7FFF, 8'hC3, 8'h5A);
    chk("hold_addr", 32'(ram_addr), 32'h7FFF);
    chk("hold_wdata", 32'(ram_wdata), 32'hC3);

    // Tie after reset: cpu, dma, cpu, dma with both requests held throughout.
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_owner", 32'(owner), 32'd1);
    chk("rst2_rd", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tie%0d_owner", k), 32'(owner), 32'(k % 2));
      chk($sformatf("tie%0d_addr", k), 32'(ram_addr), (k % 2) ? 32'h0011 : 32'h0100);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("tie%0d_ack", k), 32'({cpu_ack, dma_ack}), (k % 2) ? 32'd1 : 32'd2);
      chk($sformatf("tie%0d_rd", k), 32'(rd_data), (k % 2) ? 32'hB4 : 32'h5A);
      @(negedge clk);
      chk($sformatf("tie%0d_idle", k), 32'(busy), 32'd0);
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;

    // Withdrawn dma request still completes with a single ack.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0022;
    @(negedge clk);
    chk("wd_en", 32'(ram_en), 32'd1);
    chk("wd_owner", 32'(owner), 32'd1);
    dma_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acks += int'(dma_ack) + int'(cpu_ack) * 16;
    end
    chk("wd_ack_cnt", 32'(acks), 32'd1);
    chk("wd_rd", 32'(rd_data), 32'h87);

    // Reset in the second ACCESS cycle of a write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0055; cpu_wdata = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_we_before", 32'(ram_we), 32'd1);
    #2;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("rmid_async_en_we", 32'({ram_en, ram_we}), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acks += int'(cpu_ack) + int'(dma_ack);
    end
    chk("rmid_no_ack", 32'(acks), 32'd0);
    run_txn("post_rst", 1'b0, 1'b0, 15'h0123, 8'h00, 8'h86);

    // WAIT_CYC=15 read, bounded by a 40-cycle budget.
    cpu_req15 = 1'b1;
    en_cnt = 0;
    ack_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ram_en15) en_cnt++;
      if (cpu_ack15) begin
        ack_cyc = c;
        break;
      end
    end
    cpu_req15 = 1'b0;
    chk("long_en_cycles", 32'(en_cnt), 32'd15);
    chk("long_ack_cycle", 32'(ack_cyc), 32'd16);
    chk("long_rd", 32'(rd_data15), 32'h5A);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
